// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared types and constants for the byte-serial memory controller.
//   - state_e   : sequencer states (idle, fetch read, load read, store write)
//   - grant_e   : which requester was served last (round-robin memory)
//   - F3_*      : funct3 access-size codes used by loads and stores
//   - xfer_bytes: funct3 -> number of byte accesses (1, 2 or 4)
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_RD  = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_MEM_WR = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Stores share the low two bits with the loads
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Only the low two funct3 bits select the width; bit 2 is the unsigned flag.
  function automatic logic [2:0] xfer_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   xfer_bytes = 3'd1;
      2'b01:   xfer_bytes = 3'd2;
      default: xfer_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext
//   Combinational load extender: takes the little-endian assembled word and
//   the load funct3 and produces the architecturally visible load result.
//   Ports:
//     word  in  32  assembled bytes (byte 0 in [7:0])
//     size  in  3   funct3 of the load
//     rdata out 32  sign/zero-extended result
module mem_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  size,
  output logic [31:0] rdata
);

  always_comb begin
    case (size)
      F3_LB:   rdata = {{24{word[7]}}, word[7:0]};
      F3_LH:   rdata = {{16{word[15]}}, word[15:0]};
      F3_LBU:  rdata = {24'h000000, word[7:0]};
      F3_LHU:  rdata = {16'h0000, word[15:0]};
      default: rdata = word;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
//   Shares one byte-wide synchronous RAM port between instruction fetch and
//   the MEM stage. Each request is split into 1/2/4 byte accesses; read bytes
//   are assembled little-endian and extended, writes emit one byte per cycle.
//   Ports:
//     clk_in, rst_in (async, active-high), rdy_in (0 = global stall)
//     if_req/if_addr/if_flush  -> if_done/if_data     instruction fetch side
//     mem_req/mem_wr/mem_size/mem_addr/mem_wdata -> mem_done/mem_rdata
//     ram_din (1-cycle read latency) / ram_dout / ram_addr / ram_wr
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  mem_req,
  input  logic                  mem_wr,
  input  logic [2:0]            mem_size,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr
);

  state_e                state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            size_q, size_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           word_q, word_d;
  logic [7:0]            hold_byte_q, hold_byte_d;
  logic                  hold_vld_q, hold_vld_d;
  logic                  stall_q, stall_d;
  logic                  if_done_q, if_done_d;
  logic [31:0]           if_data_q, if_data_d;
  logic                  mem_done_q, mem_done_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  ram_wr_q, ram_wr_d;

  logic [2:0]  n_bytes;
  logic [7:0]  rd_byte;
  logic [31:0] word_asm;
  logic [31:0] ext_word;
  logic        is_read;
  logic        grant_if, grant_mem;

  assign n_bytes = xfer_bytes(size_q);
  assign is_read = (state_q == ST_IF_RD) || (state_q == ST_MEM_RD);

  // The byte that was in flight when a stall began is parked in hold_byte;
  // the frozen ram_addr then re-presents the next read once rdy_in returns,
  // so a stall of S cycles delays completion by exactly S cycles.
  assign rd_byte = hold_vld_q ? hold_byte_q : ram_din;

  // In read cycle cnt (cnt >= 1) the RAM returns byte cnt-1.
  always_comb begin
    word_asm = word_q;
    for (int b = 0; b < 4; b++) begin
      if (cnt_q == 3'(b + 1)) word_asm[8*b +: 8] = rd_byte;
    end
  end

  mem_load_ext u_load_ext (
    .word  (word_asm),
    .size  (size_q),
    .rdata (ext_word)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    hold_byte_d  = hold_byte_q;
    hold_vld_d   = hold_vld_q;
    stall_d      = ~rdy_in;
    if_done_d    = if_done_q;
    if_data_d    = if_data_q;
    mem_done_d   = mem_done_q;
    mem_rdata_d  = mem_rdata_q;
    ram_addr_d   = ram_addr_q;
    ram_dout_d   = ram_dout_q;
    ram_wr_d     = ram_wr_q;
    grant_if     = 1'b0;
    grant_mem    = 1'b0;

    if (!rdy_in) begin
      // Everything freezes; only catch the byte answering the last active cycle.
      if (is_read && cnt_q != 3'd0 && !stall_q) begin
        hold_byte_d = ram_din;
        hold_vld_d  = 1'b1;
      end
    end else begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      hold_vld_d = 1'b0;

      case (state_q)
        ST_IDLE: begin
          // A done pulse means the requester has not yet dropped its request.
          if (!if_done_q && !mem_done_q) begin
            if (mem_req && if_req && !if_flush) grant_mem = (last_grant_q == GRANT_IF);
            else                                grant_mem = mem_req;
            grant_if = if_req && !if_flush && !grant_mem;
          end
          if (grant_mem) begin
            state_d      = mem_wr ? ST_MEM_WR : ST_MEM_RD;
            last_grant_d = GRANT_MEM;
            cnt_d        = 3'd0;
            size_d       = mem_size;
            wdata_d      = mem_wdata;
            word_d       = ZERO_WORD;
            ram_addr_d   = mem_addr;
            ram_dout_d   = mem_wr ? mem_wdata[7:0] : ram_dout_q;
            ram_wr_d     = mem_wr;
          end else if (grant_if) begin
            state_d      = ST_IF_RD;
            last_grant_d = GRANT_IF;
            cnt_d        = 3'd0;
            size_d       = F3_LW;
            word_d       = ZERO_WORD;
            ram_addr_d   = if_addr;
          end
        end

        ST_IF_RD, ST_MEM_RD: begin
          if (state_q == ST_IF_RD && if_flush) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
          end else begin
            word_d = word_asm;
            if (cnt_q == n_bytes) begin
              state_d = ST_IDLE;
              cnt_d   = 3'd0;
              if (state_q == ST_IF_RD) begin
                if_done_d = 1'b1;
                if_data_d = word_asm;
              end else begin
                mem_done_d  = 1'b1;
                mem_rdata_d = ext_word;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
              // The last address stays on the bus while its data comes back.
              if (cnt_q + 3'd1 < n_bytes) ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
            end
          end
        end

        ST_MEM_WR: begin
          if (cnt_q == n_bytes - 3'd1) begin
            state_d    = ST_IDLE;
            cnt_d      = 3'd0;
            ram_wr_d   = 1'b0;
            mem_done_d = 1'b1;
          end else begin
            cnt_d      = cnt_q + 3'd1;
            ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
            for (int b = 0; b < 4; b++) begin
              if (cnt_q + 3'd1 == 3'(b)) ram_dout_d = wdata_q[8*b +: 8];
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_IF;
      cnt_q        <= 3'd0;
      size_q       <= 3'd0;
      wdata_q      <= ZERO_WORD;
      word_q       <= ZERO_WORD;
      hold_byte_q  <= 8'h00;
      hold_vld_q   <= 1'b0;
      stall_q      <= 1'b0;
      if_done_q    <= 1'b0;
      if_data_q    <= ZERO_WORD;
      mem_done_q   <= 1'b0;
      mem_rdata_q  <= ZERO_WORD;
      ram_addr_q   <= '0;
      ram_dout_q   <= 8'h00;
      ram_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
      hold_byte_q  <= hold_byte_d;
      hold_vld_q   <= hold_vld_d;
      stall_q      <= stall_d;
      if_done_q    <= if_done_d;
      if_data_q    <= if_data_d;
      mem_done_q   <= mem_done_d;
      mem_rdata_q  <= mem_rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_dout_q   <= ram_dout_d;
      ram_wr_q     <= ram_wr_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_dout  = ram_dout_q;
  // A stalled write cycle must not reach the RAM; it is replayed on resume.
  assign ram_wr    = ram_wr_q & rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_data;
  logic        mem_req, mem_wr, mem_done;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_addr;
  logic        ram_wr;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Synchronous RAM model, 1 KiB aliased over the address space.
  logic [7:0] ram_mem [0:1023];
  always @(posedge clk_in) begin
    ram_din <= ram_mem[ram_addr[9:0]];
    if (ram_wr) ram_mem[ram_addr[9:0]] <= ram_dout;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp_v);
    end
  endtask

  // Scoreboard: expectations queued at request time, consumed on done.
  typedef struct {logic chk; logic [31:0] val;} exp_t;
  exp_t exp_if[$];
  exp_t exp_mem[$];
  exp_t e_if, e_mem;

  always @(negedge clk_in) begin
    if (!rst_in && if_done) begin
      if (exp_if.size() == 0) check("if_unexpected_done", 32'd1, 32'd0);
      else begin
        e_if = exp_if.pop_front();
        check("if_data", if_data, e_if.val);
      end
    end
    if (!rst_in && mem_done) begin
      if (exp_mem.size() == 0) check("mem_unexpected_done", 32'd1, 32'd0);
      else begin
        e_mem = exp_mem.pop_front();
        if (e_mem.chk) check("mem_rdata", mem_rdata, e_mem.val);
      end
    end
  end

  typedef struct {int c; logic [31:0] a; logic [7:0] d;} wr_t;
  wr_t wr_log[$];
  always @(negedge clk_in) if (ram_wr) wr_log.push_back('{cyc, ram_addr, ram_dout});

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic preload(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) ram_mem[10'(a + k)] <= w[8*k +: 8];
  endtask

  task automatic wait_done(input logic is_mem, output int c);
    c = -1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (is_mem ? mem_done : if_done) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check(is_mem ? "mem_timeout" : "if_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_if(input logic [31:0] a, input logic [31:0] exp_v, input int lat, input string tag);
    int t0, c;
    if_req = 1'b1; if_addr = a;
    exp_if.push_back('{1'b1, exp_v});
    t0 = cyc;
    wait_done(1'b0, c);
    check({tag, "_lat"}, 32'(c - t0), 32'(lat));
    if_req = 1'b0;
    $display("[TB] %s addr=0x%08h data=0x%08h latency=%0d", tag, a, if_data, c - t0);
    tick();
  endtask

  task automatic do_mem(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_v, input int lat,
                        input string tag);
    int t0, c;
    mem_req = 1'b1; mem_wr = wr; mem_size = sz; mem_addr = a; mem_wdata = wd;
    exp_mem.push_back('{~wr, exp_v});
    t0 = cyc;
    wait_done(1'b1, c);
    check({tag, "_lat"}, 32'(c - t0), 32'(lat));
    mem_req = 1'b0;
    $display("[TB] %s wr=%0b size=%03b addr=0x%08h rdata=0x%08h latency=%0d",
             tag, wr, sz, a, mem_rdata, c - t0);
    tick();
  endtask

  task automatic reset_dut();
    rst_in = 1'b1;
    tick(); tick();
    rst_in = 1'b0;
    tick();
  endtask

  initial begin
    int t0, c, who;
    logic [3:0] order;
    rst_in = 1'b1; rdy_in = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_wr = 1'b0; mem_size = 3'b000; mem_addr = '0; mem_wdata = '0;
    for (int i = 0; i < 1024; i++) ram_mem[i] <= 8'h00;
    preload(32'h100, 32'h0000_0513);
    preload(32'h020, 32'h0000_0080);
    preload(32'h022, 32'h0000_9234);
    preload(32'h024, 32'h1234_5678);
    preload(32'h3FE, 32'hDDCC_BBAA);
    tick(); tick();

    // Reset values
    check("rst_if_done",   {31'd0, if_done},  32'd0);
    check("rst_mem_done",  {31'd0, mem_done}, 32'd0);
    check("rst_if_data",   if_data,           32'd0);
    check("rst_mem_rdata", mem_rdata,         32'd0);
    check("rst_ram_addr",  ram_addr,          32'd0);
    check("rst_ram_dout",  {24'd0, ram_dout}, 32'd0);
    check("rst_ram_wr",    {31'd0, ram_wr},   32'd0);
    rst_in = 1'b0;
    tick();

    // Fetch and loads
    do_if(32'h100, 32'h0000_0513, 6, "if_fetch");
    do_mem(1'b0, F3_LB,  32'h20, 32'h0, 32'hFFFF_FF80, 3, "lb");
    do_mem(1'b0, F3_LBU, 32'h20, 32'h0, 32'h0000_0080, 3, "lbu");
    do_mem(1'b0, F3_LH,  32'h22, 32'h0, 32'hFFFF_9234, 4, "lh");
    do_mem(1'b0, F3_LHU, 32'h22, 32'h0, 32'h0000_9234, 4, "lhu");
    do_mem(1'b0, F3_LW,  32'h24, 32'h0, 32'h1234_5678, 6, "lw");
    do_mem(1'b0, F3_LW,  32'hFFFF_FFFE, 32'h0, 32'hDDCC_BBAA, 6, "lw_wrap");

    // Stores
    wr_log.delete();
    t0 = cyc;
    do_mem(1'b1, F3_SH, 32'h40, 32'hDEAD_BEEF, 32'h0, 3, "sh");
    check("sh_wr_count", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      check("sh_wr0_cyc",  32'(wr_log[0].c - t0), 32'd1);
      check("sh_wr0_addr", wr_log[0].a, 32'h40);
      check("sh_wr0_data", {24'd0, wr_log[0].d}, 32'hEF);
      check("sh_wr1_cyc",  32'(wr_log[1].c - t0), 32'd2);
      check("sh_wr1_addr", wr_log[1].a, 32'h41);
      check("sh_wr1_data", {24'd0, wr_log[1].d}, 32'hBE);
    end
    check("sh_no_byte2", {24'd0, ram_mem[10'h042]}, 32'h0);
    do_mem(1'b1, F3_SW, 32'h50, 32'hA1B2_C3D4, 32'h0, 5, "sw");
    do_mem(1'b0, F3_LW, 32'h50, 32'h0, 32'hA1B2_C3D4, 6, "lw_after_sw");
    do_mem(1'b0, F3_LB, 32'h53, 32'h0, 32'hFFFF_FFA1, 3, "lb_after_sw");
    do_mem(1'b1, F3_SB, 32'h58, 32'h0000_007E, 32'h0, 2, "sb");
    do_mem(1'b0, F3_LW, 32'h58, 32'h0, 32'h0000_007E, 6, "lw_after_sb");

    // Arbitration: both requesting from reset -> MEM, IF, MEM, IF
    reset_dut();
    order = 4'b0101;
    if_req = 1'b1; if_addr = 32'h100; exp_if.push_back('{1'b1, 32'h0000_0513});
    mem_req = 1'b1; mem_wr = 1'b0; mem_size = F3_LW; mem_addr = 32'h24;
    exp_mem.push_back('{1'b1, 32'h1234_5678});
    for (int i = 0; i < 4; i++) begin
      c = -1;
      for (int j = 0; j < 50; j++) begin
        tick();
        if (if_done || mem_done) begin
          c = cyc;
          break;
        end
      end
      if (c < 0) begin
        check("arb_timeout", 32'd0, 32'd1);
        break;
      end
      who = mem_done ? 1 : 0;
      check("arb_order", 32'(who), {31'd0, order[i]});
      $display("[TB] arb grant %0d served %s at cycle %0d", i, (who == 1) ? "MEM" : "IF", c);
      if (i < 3) begin
        if (who == 1) begin
          mem_size = F3_LB; mem_addr = 32'h20;
          exp_mem.push_back('{1'b1, 32'hFFFF_FF80});
        end else begin
          exp_if.push_back('{1'b1, 32'h0000_0513});
        end
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    if (exp_mem.size() > 0) void'(exp_mem.pop_back());
    repeat (8) tick();

    // Flush of an in-flight fetch at T+3, new fetch granted at T+4
    if_req = 1'b1; if_addr = 32'h100;
    t0 = cyc;
    tick(); tick(); tick();
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0; if_addr = 32'h24;
    exp_if.push_back('{1'b1, 32'h1234_5678});
    wait_done(1'b0, c);
    check("flush_refetch_lat", 32'(c - t0), 32'd10);
    if_req = 1'b0;
    $display("[TB] flush_in_if_rd refetch data=0x%08h done at T+%0d", if_data, c - t0);
    tick();

    // Flush in IDLE blocks a same-cycle fetch grant for that cycle
    if_req = 1'b1; if_addr = 32'h100; if_flush = 1'b1;
    exp_if.push_back('{1'b1, 32'h0000_0513});
    t0 = cyc;
    tick();
    if_flush = 1'b0;
    wait_done(1'b0, c);
    check("flush_idle_lat", 32'(c - t0), 32'd7);
    if_req = 1'b0;
    $display("[TB] flush_in_idle data=0x%08h done at T+%0d", if_data, c - t0);
    tick();

    // Flush never touches a MEM transaction
    if_flush = 1'b1;
    do_mem(1'b0, F3_LW, 32'h24, 32'h0, 32'h1234_5678, 6, "lw_under_flush");
    if_flush = 1'b0;

    // Stall 3 cycles in the middle of a LW
    mem_req = 1'b1; mem_wr = 1'b0; mem_size = F3_LW; mem_addr = 32'h24;
    exp_mem.push_back('{1'b1, 32'h1234_5678});
    t0 = cyc;
    tick(); tick(); tick();
    rdy_in = 1'b0;
    tick(); tick(); tick();
    rdy_in = 1'b1;
    wait_done(1'b1, c);
    check("lw_stall_lat", 32'(c - t0), 32'd9);
    mem_req = 1'b0;
    $display("[TB] lw_stall rdata=0x%08h latency=%0d", mem_rdata, c - t0);
    tick();

    // Stall 2 cycles during a SW: no RAM writes while stalled
    wr_log.delete();
    mem_req = 1'b1; mem_wr = 1'b1; mem_size = F3_SW; mem_addr = 32'h60; mem_wdata = 32'hCAFE_F00D;
    exp_mem.push_back('{1'b0, 32'h0});
    t0 = cyc;
    tick(); tick();
    rdy_in = 1'b0;
    tick(); tick();
    rdy_in = 1'b1;
    wait_done(1'b1, c);
    check("sw_stall_lat", 32'(c - t0), 32'd7);
    check("sw_stall_wr_count", 32'(wr_log.size()), 32'd4);
    mem_req = 1'b0;
    $display("[TB] sw_stall latency=%0d writes=%0d", c - t0, wr_log.size());
    tick();
    do_mem(1'b0, F3_LW, 32'h60, 32'h0, 32'hCAFE_F00D, 6, "lw_after_sw_stall");

    // Reset in the middle of a SW
    mem_req = 1'b1; mem_wr = 1'b1; mem_size = F3_SW; mem_addr = 32'h80; mem_wdata = 32'h1122_3344;
    tick(); tick();
    #2 rst_in = 1'b1;
    #1;
    check("rst_mid_ram_wr",   {31'd0, ram_wr},   32'd0);
    check("rst_mid_ram_addr", ram_addr,          32'd0);
    check("rst_mid_ram_dout", {24'd0, ram_dout}, 32'd0);
    check("rst_mid_mem_done", {31'd0, mem_done}, 32'd0);
    mem_req = 1'b0;
    tick(); tick();
    rst_in = 1'b0;
    repeat (6) tick();
    check("rst_mid_byte0", {24'd0, ram_mem[10'h080]}, 32'h44);
    check("rst_mid_byte1", {24'd0, ram_mem[10'h081]}, 32'h00);
    $display("[TB] reset during sw aborted after first byte");

    check("if_queue_empty",  32'(exp_if.size()),  32'd0);
    check("mem_queue_empty", 32'(exp_mem.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
